// File: rtl/uart_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : uart_pkg
//  Purpose  : Shared UART framing constants and state encodings used by the
//             program dumper, the loader RX and the debugger UART.
//  Contents : DATA_BITS, START_LEVEL, STOP_LEVEL, DEFAULT_CLKS_PER_BIT,
//             ADR_W, dumper_state_t (IDLE/WAIT/READ/SEND),
//             frame_state_t (IDLE/START/DATA/STOP)
//  Revision : 1.0 - initial release
// ============================================================================
package uart_pkg;

    localparam int unsigned DATA_BITS            = 8;
    localparam logic        START_LEVEL          = 1'b0;
    localparam logic        STOP_LEVEL           = 1'b1;
    localparam int unsigned DEFAULT_CLKS_PER_BIT = 104;
    localparam int unsigned ADR_W                = 21;

    // Dumper control: SEND covers the START/DATA/STOP sub-states that the
    // frame transmitter owns.
    typedef enum logic [1:0] {
        DMP_IDLE = 2'd0,
        DMP_WAIT = 2'd1,
        DMP_READ = 2'd2,
        DMP_SEND = 2'd3
    } dumper_state_t;

    typedef enum logic [1:0] {
        FRM_IDLE  = 2'd0,
        FRM_START = 2'd1,
        FRM_DATA  = 2'd2,
        FRM_STOP  = 2'd3
    } frame_state_t;

endpackage
`default_nettype wire

// File: rtl/uart_tx_frame.sv
`default_nettype none
// ============================================================================
//  Module   : uart_tx_frame
//  Purpose  : Serialises one byte as an 8N1 frame, LSB first, CLKS_PER_BIT
//             clocks per bit. Owns the START/DATA/STOP sub-states and the
//             baud counter.
//  Ports    : clk     - system clock
//             n_reset - synchronous active-low reset
//             load    - accept data; honoured only while idle=1
//             data    - byte to transmit
//             tx      - serial line, idle high (registered)
//             idle    - a load presented this cycle is accepted; also high
//                       during the final STOP cycle so frames can abut
//  Revision : 1.0 - initial release
// ============================================================================
module uart_tx_frame
    import uart_pkg::*;
#(
    parameter int unsigned CLKS_PER_BIT = DEFAULT_CLKS_PER_BIT
) (
    input  logic                 clk,
    input  logic                 n_reset,
    input  logic                 load,
    input  logic [DATA_BITS-1:0] data,
    output logic                 tx,
    output logic                 idle
);

    localparam int unsigned      BAUD_W   = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
    localparam logic [BAUD_W-1:0] BAUD_MAX = BAUD_W'(CLKS_PER_BIT - 1);
    localparam int unsigned      BIT_W    = $clog2(DATA_BITS);
    localparam logic [BIT_W-1:0] BIT_LAST = BIT_W'(DATA_BITS - 1);

    frame_state_t           r_state;
    frame_state_t           w_state_nxt;
    logic [BAUD_W-1:0]      r_baud;
    logic [BIT_W-1:0]       r_bit;
    logic [DATA_BITS-1:0]   r_sh;
    logic                   r_tx;
    logic                   w_baud_zero;
    logic                   w_idle;

    assign w_baud_zero = (r_baud == '0);
    assign w_idle      = (r_state == FRM_IDLE) || ((r_state == FRM_STOP) && w_baud_zero);
    assign idle        = w_idle;
    assign tx          = r_tx;

    always_ff @(posedge clk) begin
        if (!n_reset) r_state <= FRM_IDLE;
        else          r_state <= w_state_nxt;
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            FRM_IDLE:  if (load) w_state_nxt = FRM_START;
            FRM_START: if (w_baud_zero) w_state_nxt = FRM_DATA;
            FRM_DATA:  if (w_baud_zero && (r_bit == BIT_LAST)) w_state_nxt = FRM_STOP;
            FRM_STOP:  if (w_baud_zero) w_state_nxt = load ? FRM_START : FRM_IDLE;
            default:   w_state_nxt = FRM_IDLE;
        endcase
    end

    // tx is registered and set one edge ahead of each bit so the line never
    // glitches on state decode.
    always_ff @(posedge clk) begin
        if (!n_reset) begin
            r_baud <= '0;
            r_bit  <= '0;
            r_sh   <= '0;
            r_tx   <= STOP_LEVEL;
        end else if (w_idle && load) begin
            r_baud <= BAUD_MAX;
            r_bit  <= '0;
            r_sh   <= data;
            r_tx   <= START_LEVEL;
        end else begin
            case (r_state)
                FRM_START: begin
                    if (w_baud_zero) begin
                        r_baud <= BAUD_MAX;
                        r_tx   <= r_sh[0];
                    end else begin
                        r_baud <= r_baud - 1'b1;
                    end
                end
                FRM_DATA: begin
                    if (w_baud_zero) begin
                        r_baud <= BAUD_MAX;
                        if (r_bit == BIT_LAST) begin
                            r_tx <= STOP_LEVEL;
                        end else begin
                            r_bit <= r_bit + 1'b1;
                            r_sh  <= {1'b0, r_sh[DATA_BITS-1:1]};
                            r_tx  <= r_sh[1];
                        end
                    end else begin
                        r_baud <= r_baud - 1'b1;
                    end
                end
                FRM_STOP: begin
                    if (!w_baud_zero) r_baud <= r_baud - 1'b1;
                end
                default: ;
            endcase
        end
    end

endmodule
`default_nettype wire

// File: rtl/prog_dumper.sv
`default_nettype none
// ============================================================================
//  Module   : prog_dumper
//  Purpose  : Reads a contiguous range of the 21-bit external bus and streams
//             each byte out over UART TX (8N1, LSB first) so the host can
//             verify a loaded image.
//  Ports    : clk       - system clock (UART domain)
//             n_reset   - synchronous active-low reset
//             start     - one-cycle request, dropped while busy
//             start_adr - first byte address, sampled on accepted start
//             length    - byte count, sampled on accepted start (0 = none)
//             hold      - host flow control, sampled only between bytes
//             adr       - external bus address
//             read      - active-high read strobe
//             din       - external bus data
//             tx        - UART TX line, idle high
//             busy      - transfer in progress
//             done      - one-cycle pulse at end of transfer
//  Revision : 1.0 - initial release
// ============================================================================
module prog_dumper
    import uart_pkg::*;
#(
    parameter int unsigned CLKS_PER_BIT = DEFAULT_CLKS_PER_BIT,
    parameter int unsigned READ_CYCLES  = 2
) (
    input  logic             clk,
    input  logic             n_reset,
    input  logic             start,
    input  logic [ADR_W-1:0] start_adr,
    input  logic [ADR_W-1:0] length,
    input  logic             hold,
    output logic [ADR_W-1:0] adr,
    output logic             read,
    input  logic [7:0]       din,
    output logic             tx,
    output logic             busy,
    output logic             done
);

    localparam int unsigned     RD_W    = $clog2(READ_CYCLES + 1);
    localparam logic [RD_W-1:0] RD_LAST = RD_W'(READ_CYCLES - 1);

    dumper_state_t      r_state;
    dumper_state_t      w_state_nxt;
    logic [ADR_W-1:0]   r_adr;
    logic [ADR_W-1:0]   r_remaining;
    logic [RD_W-1:0]    r_rd_cnt;
    logic               r_done;
    logic               w_rd_last;
    logic               w_load;
    logic               w_frame_idle;
    logic               w_last_byte;

    assign w_rd_last   = (r_rd_cnt == RD_LAST);
    assign w_load      = (r_state == DMP_READ) && w_rd_last;
    assign w_last_byte = (r_remaining == ADR_W'(1));

    assign adr  = r_adr;
    assign read = (r_state == DMP_READ);
    assign busy = (r_state != DMP_IDLE);
    assign done = r_done;

    // din is captured by the frame on the last read cycle via load.
    uart_tx_frame #(
        .CLKS_PER_BIT (CLKS_PER_BIT)
    ) u_frame (
        .clk     (clk),
        .n_reset (n_reset),
        .load    (w_load),
        .data    (din),
        .tx      (tx),
        .idle    (w_frame_idle)
    );

    always_ff @(posedge clk) begin
        if (!n_reset) r_state <= DMP_IDLE;
        else          r_state <= w_state_nxt;
    end

    // In SEND the frame reports idle only during its final STOP cycle,
    // which is when the byte is retired.
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            DMP_IDLE: if (start && (length != '0)) w_state_nxt = DMP_WAIT;
            DMP_WAIT: if (!hold) w_state_nxt = DMP_READ;
            DMP_READ: if (w_rd_last) w_state_nxt = DMP_SEND;
            DMP_SEND: if (w_frame_idle) w_state_nxt = w_last_byte ? DMP_IDLE : DMP_WAIT;
            default:  w_state_nxt = DMP_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!n_reset) begin
            r_adr       <= '0;
            r_remaining <= '0;
            r_rd_cnt    <= '0;
            r_done      <= 1'b0;
        end else begin
            r_done <= 1'b0;
            case (r_state)
                DMP_IDLE: begin
                    if (start) begin
                        if (length != '0) begin
                            r_adr       <= start_adr;
                            r_remaining <= length;
                        end else begin
                            r_done <= 1'b1;
                        end
                    end
                end
                DMP_WAIT: r_rd_cnt <= '0;
                DMP_READ: if (!w_rd_last) r_rd_cnt <= r_rd_cnt + 1'b1;
                DMP_SEND: begin
                    if (w_frame_idle) begin
                        r_adr       <= r_adr + 1'b1;  // wraps at 2^21
                        r_remaining <= r_remaining - 1'b1;
                        if (w_last_byte) r_done <= 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_prog_dumper.sv
`default_nettype none
// ============================================================================
//  Module   : tb_prog_dumper
//  Purpose  : Directed self-checking bench for prog_dumper with
//             CLKS_PER_BIT=4, READ_CYCLES=2. A line decoder rebuilds frames
//             from tx, a bus monitor logs read pulses, and directed steps
//             compare against hand-computed values.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_prog_dumper;

    localparam int CPB = 4;
    localparam int RC  = 2;

    logic        clk = 1'b0;
    logic        n_reset = 1'b0;
    logic        start = 1'b0;
    logic        hold = 1'b0;
    logic [20:0] start_adr = '0;
    logic [20:0] length = '0;
    logic [20:0] adr;
    logic        read;
    logic [7:0]  din;
    logic [7:0]  mask = 8'h00;
    logic        tx;
    logic        busy;
    logic        done;

    // Memory model: low byte of the address, optionally XORed.
    assign din = adr[7:0] ^ mask;

    always #5 clk = ~clk;

    prog_dumper #(
        .CLKS_PER_BIT (CPB),
        .READ_CYCLES  (RC)
    ) dut (
        .clk       (clk),
        .n_reset   (n_reset),
        .start     (start),
        .start_adr (start_adr),
        .length    (length),
        .hold      (hold),
        .adr       (adr),
        .read      (read),
        .din       (din),
        .tx        (tx),
        .busy      (busy),
        .done      (done)
    );

    int checks = 0;
    int errors = 0;
    int cyc    = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    always @(posedge clk) cyc++;

    // ---------------- line decoder ----------------
    logic [7:0]  rx_bytes[$];
    int          rx_start[$];
    logic [39:0] m_smp;
    int          m_ph = 0;
    bit          m_act = 1'b0;

    always @(negedge clk) begin
        if (!n_reset) begin
            m_act = 1'b0;
        end else begin
            if (!m_act && tx === 1'b0) begin
                m_act = 1'b1;
                m_ph  = 0;
                rx_start.push_back(cyc);
            end
            if (m_act) begin
                m_smp[m_ph] = tx;
                m_ph++;
                if (m_ph == 10 * CPB) begin
                    logic       ok;
                    logic [7:0] d;
                    m_act = 1'b0;
                    ok = (m_smp[0] === 1'b0) && (m_smp[36] === 1'b1);
                    for (int b = 0; b < 10; b++)
                        for (int s = 1; s < CPB; s++)
                            if (m_smp[b*CPB+s] !== m_smp[b*CPB]) ok = 1'b0;
                    for (int i = 0; i < 8; i++) d[i] = m_smp[(i+1)*CPB];
                    chk("frame_shape", 32'(ok), 32'd1);
                    rx_bytes.push_back(d);
                end
            end
        end
    end

    // ---------------- bus / done monitor ----------------
    logic [20:0] rd_adr[$];
    int          rd_run = 0;
    int          done_cnt = 0;

    always @(negedge clk) begin
        if (!n_reset) begin
            rd_run = 0;
        end else if (read === 1'b1) begin
            if (rd_run == 0) rd_adr.push_back(adr);
            rd_run++;
        end else if (rd_run != 0) begin
            chk("read_len", 32'(rd_run), 32'(RC));
            rd_run = 0;
        end
        if (done === 1'b1) done_cnt++;
    end

    // ---------------- helpers ----------------
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic go(input logic [20:0] a, input logic [20:0] l);
        start     = 1'b1;
        start_adr = a;
        length    = l;
        tick();
        start     = 1'b0;
    endtask

    task automatic wait_done(input int limit);
        int n = 0;
        while (done !== 1'b1 && n < limit) begin
            tick();
            n++;
        end
        chk("done_seen", 32'(done), 32'd1);
    endtask

    task automatic wait_rx(input int cnt, input int limit);
        int n = 0;
        while (rx_bytes.size() < cnt && n < limit) begin
            tick();
            n++;
        end
        chk("rx_wait", 32'(rx_bytes.size()), 32'(cnt));
    endtask

    function automatic logic [31:0] rxq(input int i);
        if (i < rx_bytes.size()) return 32'(rx_bytes[i]);
        return 32'hFFFF_FFFF;
    endfunction

    function automatic logic [31:0] rdq(input int i);
        if (i < rd_adr.size()) return 32'(rd_adr[i]);
        return 32'hFFFF_FFFF;
    endfunction

    function automatic logic [31:0] gap(input int i);
        if (i + 1 < rx_start.size()) return 32'(rx_start[i+1] - rx_start[i]);
        return 32'hFFFF_FFFF;
    endfunction

    task automatic clear_logs();
        rx_bytes.delete();
        rx_start.delete();
        rd_adr.delete();
        done_cnt = 0;
    endtask

    // ---------------- directed sequence ----------------
    initial begin
        int bad;

        // Reset state
        repeat (3) tick();
        chk("rst_tx",   32'(tx),   32'd1);
        chk("rst_read", 32'(read), 32'd0);
        chk("rst_adr",  32'(adr),  32'd0);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_done", 32'(done), 32'd0);
        n_reset = 1'b1;
        tick();

        // Single byte: 0x10 ^ 0xB5 = 0xA5
        mask = 8'hB5;
        clear_logs();
        go(21'h00010, 21'd1);
        chk("t1_busy", 32'(busy), 32'd1);
        chk("t1_adr",  32'(adr),  32'h10);
        chk("t1_wait_read", 32'(read), 32'd0);
        tick();
        chk("t1_read0", 32'(read), 32'd1);
        tick();
        chk("t1_read1", 32'(read), 32'd1);
        tick();
        chk("t1_read_off", 32'(read), 32'd0);
        chk("t1_start_bit", 32'(tx), 32'd0);
        wait_done(100);
        chk("t1_adr_end", 32'(adr),  32'h11);
        chk("t1_busy_end", 32'(busy), 32'd0);
        tick();
        chk("t1_done_off", 32'(done), 32'd0);
        chk("t1_done_cnt", 32'(done_cnt), 32'd1);
        chk("t1_rx_cnt", 32'(rx_bytes.size()), 32'd1);
        chk("t1_byte", rxq(0), 32'hA5);
        chk("t1_rd_adr", rdq(0), 32'h10);

        // Wrap-around, then a start in the done cycle
        mask = 8'h00;
        clear_logs();
        go(21'h1FFFFE, 21'd3);
        wait_done(500);
        chk("t2_adr_end", 32'(adr), 32'h1);
        go(21'h00070, 21'd1);
        chk("t2_chain_busy", 32'(busy), 32'd1);
        chk("t2_chain_adr",  32'(adr),  32'h70);
        wait_done(200);
        tick();
        chk("t2_rx_cnt", 32'(rx_bytes.size()), 32'd4);
        chk("t2_b0", rxq(0), 32'hFE);
        chk("t2_b1", rxq(1), 32'hFF);
        chk("t2_b2", rxq(2), 32'h00);
        chk("t2_b3", rxq(3), 32'h70);
        chk("t2_rd0", rdq(0), 32'h1FFFFE);
        chk("t2_rd1", rdq(1), 32'h1FFFFF);
        chk("t2_rd2", rdq(2), 32'h000000);
        chk("t2_done_cnt", 32'(done_cnt), 32'd2);

        // Flow control: hold raised mid-DATA of byte 0
        clear_logs();
        go(21'h00020, 21'd2);
        repeat (10) tick();
        hold = 1'b1;
        wait_rx(1, 200);
        bad = 0;
        repeat (50) begin
            tick();
            if (read !== 1'b0 || tx !== 1'b1 || busy !== 1'b1) bad++;
        end
        chk("t3_hold_quiet", 32'(bad), 32'd0);
        hold = 1'b0;
        tick();
        chk("t3_read_resume", 32'(read), 32'd1);
        chk("t3_adr_resume",  32'(adr),  32'h21);
        wait_done(200);
        tick();
        chk("t3_b0", rxq(0), 32'h20);
        chk("t3_b1", rxq(1), 32'h21);

        // Zero length
        clear_logs();
        go(21'h00123, 21'd0);
        chk("t4_zero_done", 32'(done), 32'd1);
        chk("t4_zero_busy", 32'(busy), 32'd0);
        tick();
        chk("t4_zero_done_off", 32'(done), 32'd0);
        chk("t4_zero_tx", 32'(tx), 32'd1);
        chk("t4_zero_rd", 32'(rd_adr.size()), 32'd0);

        // Busy start dropped + back-to-back spacing
        clear_logs();
        go(21'h00040, 21'd4);
        repeat (20) tick();
        go(21'h00099, 21'd2);
        chk("t5_ignored_adr", 32'(adr), 32'h40);
        wait_done(1000);
        chk("t5_adr_end", 32'(adr), 32'h44);
        repeat (5) tick();
        chk("t5_done_cnt", 32'(done_cnt), 32'd1);
        chk("t5_rx_cnt", 32'(rx_bytes.size()), 32'd4);
        chk("t5_b0", rxq(0), 32'h40);
        chk("t5_b3", rxq(3), 32'h43);
        chk("t5_gap0", gap(0), 32'd43);
        chk("t5_gap1", gap(1), 32'd43);
        chk("t5_gap2", gap(2), 32'd43);

        // Reset during DATA bit 3
        clear_logs();
        go(21'h00055, 21'd1);
        repeat (20) tick();
        n_reset = 1'b0;
        tick();
        chk("t6_tx",   32'(tx),   32'd1);
        chk("t6_busy", 32'(busy), 32'd0);
        chk("t6_read", 32'(read), 32'd0);
        chk("t6_adr",  32'(adr),  32'd0);
        chk("t6_done", 32'(done), 32'd0);
        n_reset = 1'b1;
        repeat (2) tick();
        chk("t6_no_done", 32'(done_cnt), 32'd0);
        chk("t6_no_rx", 32'(rx_bytes.size()), 32'd0);
        go(21'h00066, 21'd1);
        wait_done(200);
        tick();
        chk("t6_rx_cnt", 32'(rx_bytes.size()), 32'd1);
        chk("t6_byte", rxq(0), 32'h66);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
